button_request_ctrl: RTL and testbench
======================================

# button_request_ctrl

Input-side conditioner for the traffic-light controller's pedestrian and emergency buttons. It synchronizes and debounces the two raw pushbuttons and turns each press into a level request, `ped_button` / `em_button`, which the controller consumes. Each request is held until the controller returns an acknowledge, then a lockout interval follows. Emergency has priority over pedestrian, and presses rejected during lockout are counted for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the filtered level changes; legal range 1..255.
- `LOCKOUT_CYCLES`, default 20: cycles a channel ignores presses after an acknowledge; legal range 0..255.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `ped_btn_raw`  in  1  raw pedestrian button, asynchronous, bouncy.
- `em_btn_raw`  in  1  raw emergency button, asynchronous, bouncy.
- `ped_ack`  in  1  controller has accepted the pedestrian request; synchronous.
- `em_ack`  in  1  controller has accepted the emergency request; synchronous.
- `ped_button`  out  1  pedestrian request to the controller; registered.
- `em_button`  out  1  emergency request to the controller; registered.
- `ped_state`  out  2  pedestrian channel state: 0 IDLE, 1 PENDING, 2 LOCKOUT.
- `em_state`  out  2  emergency channel state, same encoding.
- `ped_dropped`  out  8  saturating count of pedestrian presses rejected in LOCKOUT.
- `em_dropped`  out  8  saturating count of emergency presses rejected in LOCKOUT.

## Operation
- There are two identical channels, ped and em, each with a synchronizer, a debouncer, an edge detector and a request FSM.
- **Synchronizer:** two flip-flops per raw input. Reset value is 0.
- **Debouncer:**
  - A counter increments while the synchronized input differs from the filtered level.
  - The counter clears whenever they match.
  - When the counter would reach `DEBOUNCE_CYCLES`, the filtered level takes the synchronized value and the counter clears.
  - The filtered level resets to 0. The debouncer runs in every FSM state.
- **Press event:** a rising edge of the filtered level (filtered=1, previous filtered=0). Falling edges are ignored.
- **FSM:**
  - IDLE -> PENDING on a press.
  - PENDING -> LOCKOUT on ack; the lockout counter loads `LOCKOUT_CYCLES`. If `LOCKOUT_CYCLES`=0, PENDING -> IDLE directly.
  - LOCKOUT: the counter decrements each cycle; when it reaches 0 the FSM goes to IDLE.
  - A press in PENDING is absorbed, with no effect.
  - A press in LOCKOUT increments the dropped counter, which saturates at 255. State is unchanged.
  - Ack in IDLE or LOCKOUT is ignored.
- **Outputs:**
  - `em_button` = (em_state_next == PENDING), registered.
  - `ped_button` = (ped_state_next == PENDING) AND NOT (em_state_next == PENDING), registered. While emergency is pending, the pedestrian request stays latched but is masked.
  - `ped_ack` is honoured only when `ped_button` is high in that cycle. An ack arriving while masked is ignored.
- **Reset (asynchronous, any time, including mid-PENDING or mid-LOCKOUT):**
  - All outputs go to 0 immediately: both states IDLE, both requests 0, both dropped counts 0.
  - Synchronizers, filtered levels, and debounce and lockout counters clear.
  - A button held through reset release is seen as a new press once debounced.

## Timing
- **Press latency:** let edge 1 be the first rising edge that samples the raw input high, with the raw input stable from then on. The request output is high after edge `DEBOUNCE_CYCLES`+3 (edge 7 at default).
- **Release:** a debounced release produces no output change.
- **Ack:** the request output is 0 after the edge that samples ack=1; one-cycle ack pulses are sufficient. Holding ack high longer has no further effect.
- **Lockout:** state is IDLE after `LOCKOUT_CYCLES` edges following the ack edge. A press event on that same edge, with state already IDLE, is accepted.
- **Simultaneous press and ack in PENDING:** ack wins; go to LOCKOUT and do not count a drop.
- **Simultaneous em and ped presses:** both go PENDING, `em_button`=1, `ped_button`=0. After em is acknowledged, `ped_button` rises on the same edge at which `em_button` falls.
- **Bounce:** any glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no press.

## Test plan
- **Clean press:** reset low 2 cycles then high; hold `ped_btn_raw`=1 from edge 1 -> `ped_button`=1 after edge 7, `ped_state`=1. `ped_ack` pulsed for 1 cycle -> `ped_button`=0 next edge, `ped_state`=2. `ped_state`=0 exactly 20 edges later.
- **Bounce rejection:** `em_btn_raw` toggles with 3-cycle high pulses separated by 1-cycle lows for 40 cycles -> `em_button` stays 0. Then hold high 10 cycles -> `em_button`=1.
- **Priority:** both raw inputs rise on the same edge -> `em_button`=1 and `ped_button`=0 after edge 7. `em_ack` pulse -> `em_button`=0 and `ped_button`=1 on the same edge. A `ped_ack` driven while masked is ignored.
- **Lockout drops:** after a ped ack, issue 3 debounced presses inside the 20-cycle lockout -> `ped_dropped`=3, no request. A press after lockout -> request. Force 300 drops -> `ped_dropped`=255.
- **Reset mid-operation:** assert reset while `em_state`=2 and `ped_state`=1 -> all outputs 0 asynchronously, before the next clock edge. With the button held through reset release, the request reasserts 7 edges after release.
- **Zero lockout:** with `LOCKOUT_CYCLES`=0, the ack edge returns the state to IDLE. A press 1 cycle later is accepted with no drop.

Source files
------------

// File: rtl/button_request_ctrl.sv
// Pedestrian / emergency button conditioner for the traffic-light controller.
// Each channel: 2-flop synchronizer -> debouncer -> rising-edge detect -> request FSM.
// Emergency requests mask pedestrian requests; presses during lockout are counted.
module button_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_btn_raw,
  input  logic       em_btn_raw,
  input  logic       ped_ack,
  input  logic       em_ack,
  output logic       ped_button,
  output logic       em_button,
  output logic [1:0] ped_state,
  output logic [1:0] em_state,
  output logic [7:0] ped_dropped,
  output logic [7:0] em_dropped
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StLockout = 2'd2
  } state_e;

  // Channel indices into the per-channel arrays.
  localparam int Ped = 0;
  localparam int Em  = 1;

  localparam logic [7:0] DebLast   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LockLoad  = 8'(LOCKOUT_CYCLES);
  localparam bit         NoLockout = (LOCKOUT_CYCLES == 0);

  logic [1:0] raw;
  logic [1:0] press;
  logic [1:0] ack_ok;

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] filt_q, filt_d;
  logic [1:0] filt_prev_q, filt_prev_d;
  logic [7:0] db_cnt_q   [2];
  logic [7:0] db_cnt_d   [2];
  logic [7:0] lock_cnt_q [2];
  logic [7:0] lock_cnt_d [2];
  logic [7:0] drop_q     [2];
  logic [7:0] drop_d     [2];
  state_e     state_q    [2];
  state_e     state_d    [2];
  logic       ped_button_q, ped_button_d;
  logic       em_button_q, em_button_d;

  assign raw   = {em_btn_raw, ped_btn_raw};
  assign press = filt_q & ~filt_prev_q;

  // An ack only counts while the matching request is actually visible to the controller.
  assign ack_ok = {em_ack & em_button_q, ped_ack & ped_button_q};

  // Synchronizer shift and debounce filter for both channels.
  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DebLast) begin
          filt_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Request FSM, lockout timer and saturating drop counter per channel.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]    = state_q[i];
      lock_cnt_d[i] = lock_cnt_q[i];
      drop_d[i]     = drop_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (press[i]) begin
            state_d[i] = StPending;
          end
        end
        StPending: begin
          // A press arriving with the ack is absorbed, not counted.
          if (ack_ok[i]) begin
            if (NoLockout) begin
              state_d[i] = StIdle;
            end else begin
              state_d[i]    = StLockout;
              lock_cnt_d[i] = LockLoad;
            end
          end
        end
        StLockout: begin
          if (lock_cnt_q[i] <= 8'd1) begin
            state_d[i]    = StIdle;
            lock_cnt_d[i] = '0;
          end else begin
            lock_cnt_d[i] = lock_cnt_q[i] - 8'd1;
          end
          if (press[i] && (drop_q[i] != 8'hff)) begin
            drop_d[i] = drop_q[i] + 8'd1;
          end
        end
        default: begin
          state_d[i]    = StIdle;
          lock_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Request outputs are derived from next state so they line up with state changes.
  always_comb begin
    em_button_d  = (state_d[Em] == StPending);
    ped_button_d = (state_d[Ped] == StPending) && (state_d[Em] != StPending);
  end

  // Synchronizer and debouncer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // FSM state, counters and registered request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= StIdle;
        lock_cnt_q[i] <= '0;
        drop_q[i]     <= '0;
      end
      ped_button_q <= 1'b0;
      em_button_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= state_d[i];
        lock_cnt_q[i] <= lock_cnt_d[i];
        drop_q[i]     <= drop_d[i];
      end
      ped_button_q <= ped_button_d;
      em_button_q  <= em_button_d;
    end
  end

  assign ped_button  = ped_button_q;
  assign em_button   = em_button_q;
  assign ped_state   = state_q[Ped];
  assign em_state    = state_q[Em];
  assign ped_dropped = drop_q[Ped];
  assign em_dropped  = drop_q[Em];

endmodule

// File: tb/tb_button_request_ctrl.sv
// Self-checking bench for button_request_ctrl: vector table plus hand-written
// multi-cycle sequences, with expected values queued in a scoreboard.
module tb_button_request_ctrl;

  logic       clk;
  logic       reset;
  logic       ped_btn_raw, em_btn_raw, ped_ack, em_ack;
  logic       ped_button, em_button;
  logic [1:0] ped_state, em_state;
  logic [7:0] ped_dropped, em_dropped;
  logic       z_ped_button, z_em_button;
  logic [1:0] z_ped_state, z_em_state;
  logic [7:0] z_ped_dropped, z_em_dropped;

  button_request_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ped_btn_raw (ped_btn_raw),
    .em_btn_raw  (em_btn_raw),
    .ped_ack     (ped_ack),
    .em_ack      (em_ack),
    .ped_button  (ped_button),
    .em_button   (em_button),
    .ped_state   (ped_state),
    .em_state    (em_state),
    .ped_dropped (ped_dropped),
    .em_dropped  (em_dropped)
  );

  button_request_ctrl #(
    .LOCKOUT_CYCLES (0)
  ) dut_z (
    .clk         (clk),
    .reset       (reset),
    .ped_btn_raw (ped_btn_raw),
    .em_btn_raw  (em_btn_raw),
    .ped_ack     (ped_ack),
    .em_ack      (em_ack),
    .ped_button  (z_ped_button),
    .em_button   (z_em_button),
    .ped_state   (z_ped_state),
    .em_state    (z_em_state),
    .ped_dropped (z_ped_dropped),
    .em_dropped  (z_em_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:0] want;
    logic [21:0] mask;
  } sb_t;

  typedef struct {
    string       name;
    logic        pr, er, pa, ea;
    int unsigned cyc;
    logic [21:0] want;
  } vec_t;

  localparam logic [21:0] MaskAll = 22'h3fffff;
  localparam logic [21:0] MaskPd  = 22'h00ff00;

  sb_t  sb_q[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [21:0] pack(logic pb, logic eb, logic [1:0] ps, logic [1:0] es,
                                       logic [7:0] pd, logic [7:0] ed);
    return {pb, eb, ps, es, pd, ed};
  endfunction

  function automatic logic [21:0] obs();
    return {ped_button, em_button, ped_state, em_state, ped_dropped, em_dropped};
  endfunction

  function automatic logic [21:0] obs_z();
    return {z_ped_button, z_em_button, z_ped_state, z_em_state, z_ped_dropped, z_em_dropped};
  endfunction

  function automatic string fmt(logic [21:0] v);
    return $sformatf("pb=%0b eb=%0b ps=%0d es=%0d pd=%0d ed=%0d",
                     v[21], v[20], v[19:18], v[17:16], v[15:8], v[7:0]);
  endfunction

  task automatic sb_push(string name, logic [21:0] want, logic [21:0] mask);
    sb_t e;
    e.name = name;
    e.want = want;
    e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(logic [21:0] act);
    sb_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: got %s required a queued expectation", fmt(act));
    end else begin
      e = sb_q.pop_front();
      if ((act & e.mask) !== (e.want & e.mask)) begin
        bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(act & e.mask),
                 fmt(e.want & e.mask));
      end
    end
  endtask

  task automatic expect_now(string name, logic [21:0] want);
    sb_push(name, want, MaskAll);
    sb_check(obs());
  endtask

  task automatic expect_now_z(string name, logic [21:0] want);
    sb_push(name, want, MaskAll);
    sb_check(obs_z());
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addv(string name, logic pr, logic er, logic pa, logic ea, int unsigned cyc,
                      logic pb, logic eb, logic [1:0] ps, logic [1:0] es, logic [7:0] pd);
    vec_t v;
    v.name = name;
    v.pr   = pr;
    v.er   = er;
    v.pa   = pa;
    v.ea   = ea;
    v.cyc  = cyc;
    v.want = pack(pb, eb, ps, es, pd, 8'd0);
    tbl.push_back(v);
  endtask

  int          mono_bad;
  logic [7:0]  last_pd;

  initial begin
    // name, ped_raw, em_raw, ped_ack, em_ack, edges, pb, eb, ps, es, pd
    addv("press_e6",     1, 0, 0, 0,  6, 0, 0, 2'd0, 2'd0, 8'd0);
    addv("press_e7",     1, 0, 0, 0,  1, 1, 0, 2'd1, 2'd0, 8'd0);
    addv("ped_ack",      0, 0, 1, 0,  1, 0, 0, 2'd2, 2'd0, 8'd0);
    addv("lock_hold",    0, 0, 0, 0, 19, 0, 0, 2'd2, 2'd0, 8'd0);
    addv("lock_end",     0, 0, 0, 0,  1, 0, 0, 2'd0, 2'd0, 8'd0);
    addv("both_e6",      1, 1, 0, 0,  6, 0, 0, 2'd0, 2'd0, 8'd0);
    addv("both_e7",      1, 1, 0, 0,  1, 0, 1, 2'd1, 2'd1, 8'd0);
    addv("masked_ack",   1, 1, 1, 0,  1, 0, 1, 2'd1, 2'd1, 8'd0);
    addv("em_ack_hand",  1, 1, 0, 1,  1, 1, 0, 2'd1, 2'd2, 8'd0);
    addv("ped_ack_late", 1, 1, 1, 0,  1, 0, 0, 2'd2, 2'd2, 8'd0);
    addv("em_lock_end",  0, 0, 0, 0, 19, 0, 0, 2'd2, 2'd0, 8'd0);
    addv("ped_lock_end", 0, 0, 0, 0,  1, 0, 0, 2'd0, 2'd0, 8'd0);

    reset       = 1'b1;
    ped_btn_raw = 1'b0;
    em_btn_raw  = 1'b0;
    ped_ack     = 1'b0;
    em_ack      = 1'b0;
    #2 reset = 1'b0;
    step(2);
    expect_now("reset_state", '0);
    expect_now_z("reset_state_z", '0);
    reset = 1'b1;

    // Clean press / ack / lockout, then simultaneous presses and priority hand-over.
    for (int i = 0; i < tbl.size(); i++) begin
      ped_btn_raw = tbl[i].pr;
      em_btn_raw  = tbl[i].er;
      ped_ack     = tbl[i].pa;
      em_ack      = tbl[i].ea;
      sb_push(tbl[i].name, tbl[i].want, MaskAll);
      step(tbl[i].cyc);
      sb_check(obs());
    end
    ped_ack = 1'b0;
    em_ack  = 1'b0;

    // Bounce: 3 high / 1 low never reaches the 4-cycle debounce threshold.
    for (int g = 0; g < 10; g++) begin
      em_btn_raw = 1'b1;
      step(3);
      em_btn_raw = 1'b0;
      step(1);
      expect_now($sformatf("bounce_%0d", g), '0);
    end
    em_btn_raw = 1'b1;
    step(10);
    expect_now("bounce_hold", pack(0, 1, 2'd0, 2'd1, 8'd0, 8'd0));
    em_ack = 1'b1;
    step(1);
    expect_now("bounce_ack", pack(0, 0, 2'd0, 2'd2, 8'd0, 8'd0));
    em_ack     = 1'b0;
    em_btn_raw = 1'b0;
    step(20);
    expect_now("bounce_lock_end", '0);

    // Lockout drops: ack on edge 21, presses seen on edges 22, 30, 38; lockout ends at 41.
    ped_btn_raw = 1'b1;
    step(7);
    expect_now("drop_req", pack(1, 0, 2'd1, 2'd0, 8'd0, 8'd0));
    ped_btn_raw = 1'b0;
    step(8);
    ped_btn_raw = 1'b1;
    step(4);
    ped_btn_raw = 1'b0;
    step(1);
    ped_ack = 1'b1;
    step(1);
    expect_now("drop_ack", pack(0, 0, 2'd2, 2'd0, 8'd0, 8'd0));
    ped_ack = 1'b0;
    step(2);
    ped_btn_raw = 1'b1;
    step(4);
    ped_btn_raw = 1'b0;
    step(4);
    ped_btn_raw = 1'b1;
    step(4);
    ped_btn_raw = 1'b0;
    expect_now("drop_two", pack(0, 0, 2'd2, 2'd0, 8'd2, 8'd0));
    step(3);
    expect_now("drop_three", pack(0, 0, 2'd2, 2'd0, 8'd3, 8'd0));
    step(2);
    expect_now("drop_last_lock", pack(0, 0, 2'd2, 2'd0, 8'd3, 8'd0));
    step(1);
    expect_now("drop_idle", pack(0, 0, 2'd0, 2'd0, 8'd3, 8'd0));
    ped_btn_raw = 1'b1;
    step(7);
    expect_now("after_lock_req", pack(1, 0, 2'd1, 2'd0, 8'd3, 8'd0));
    ped_ack = 1'b1;
    step(1);
    expect_now("after_lock_ack", pack(0, 0, 2'd2, 2'd0, 8'd3, 8'd0));

    // Saturation: steady press train with immediate acks drives well over 255 drops.
    mono_bad = 0;
    last_pd  = ped_dropped;
    for (int p = 0; p < 800; p++) begin
      for (int c = 0; c < 8; c++) begin
        ped_btn_raw = (c < 4);
        ped_ack     = ped_button;
        step(1);
        if (ped_dropped < last_pd) mono_bad++;
        last_pd = ped_dropped;
      end
    end
    ped_ack     = 1'b0;
    ped_btn_raw = 1'b0;
    sb_push("drop_saturate", pack(0, 0, 2'd0, 2'd0, 8'd255, 8'd0), MaskPd);
    sb_check(obs());
    total++;
    if (mono_bad != 0) begin
      bad++;
      $display("FAIL drop_monotonic: got %0d decreases required 0", mono_bad);
    end

    // Reset mid-operation with em in lockout and ped pending.
    step(30);
    ped_btn_raw = 1'b1;
    em_btn_raw  = 1'b1;
    step(7);
    expect_now("rst_setup", pack(0, 1, 2'd1, 2'd1, 8'd255, 8'd0));
    em_ack = 1'b1;
    step(1);
    expect_now("rst_setup_ack", pack(1, 0, 2'd1, 2'd2, 8'd255, 8'd0));
    em_ack     = 1'b0;
    em_btn_raw = 1'b0;
    step(2);
    #3 reset = 1'b0;
    #1;
    expect_now("rst_async", '0);
    step(1);
    expect_now("rst_held", '0);
    reset = 1'b1;
    step(6);
    expect_now("rst_rel_e6", '0);
    step(1);
    expect_now("rst_rel_e7", pack(1, 0, 2'd1, 2'd0, 8'd0, 8'd0));

    // Zero lockout: ack edge returns to IDLE, press on the following edge is accepted.
    ped_btn_raw = 1'b0;
    reset       = 1'b0;
    step(2);
    reset = 1'b1;
    ped_btn_raw = 1'b1;
    step(7);
    expect_now_z("zl_req", pack(1, 0, 2'd1, 2'd0, 8'd0, 8'd0));
    ped_btn_raw = 1'b0;
    step(8);
    ped_btn_raw = 1'b1;
    step(5);
    ped_ack = 1'b1;
    step(1);
    expect_now_z("zl_ack_idle", '0);
    ped_ack = 1'b0;
    step(1);
    expect_now_z("zl_press_next", pack(1, 0, 2'd1, 2'd0, 8'd0, 8'd0));
    ped_btn_raw = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
